// File: rtl/playfield_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : playfield_scroll_ctrl
// Purpose  : Horizontal line counter, PFHST_b strobe and buffered scroll-load
//            sequencer that borrows the VBD bus during horizontal blank.
// Revision : 1.0 - initial release
// ============================================================================
module playfield_scroll_ctrl #(
    parameter int H_TOTAL    = 456,
    parameter int H_ACTIVE   = 336,
    parameter int HSCRLD_POS = 340,
    parameter int PFHST_POS  = 448,
    parameter int GNT_WINDOW = 4
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       cpu_wr,
    input  logic [8:0] cpu_data,
    output logic       cpu_busy,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic       vbd_oe,
    output logic [8:0] vbd_out,
    output logic       hscrld_b,
    output logic       pfhst_b,
    output logic [8:0] hcount,
    output logic       hblank,
    output logic [8:0] scroll_cur,
    output logic       missed,
    input  logic       miss_clr
);

    localparam int HW = 9;
    localparam int CW = (GNT_WINDOW > 1) ? $clog2(GNT_WINDOW) : 1;

    localparam logic [HW-1:0] c_HC_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] c_HC_ONE   = HW'(1);
    localparam logic [HW-1:0] c_H_ACTIVE = HW'(H_ACTIVE);
    localparam logic [HW-1:0] c_HSCRLD   = HW'(HSCRLD_POS);
    localparam logic [HW-1:0] c_PFHST    = HW'(PFHST_POS);
    localparam logic [CW-1:0] c_WIN_LAST = CW'(GNT_WINDOW - 1);
    localparam logic [CW-1:0] c_WIN_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_DRIVE  = 3'd2,
        S_STROBE = 3'd3,
        S_HOLD   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   win_q, win_d;
    logic [HW-1:0]   hcount_q, hcount_d;
    logic            pfhst_b_q, pfhst_b_d;

    logic [8:0]      pend_q, pend_d;
    logic            busy_q, busy_d;
    logic [8:0]      cur_q, cur_d;
    logic            missed_q, missed_d;

    logic            bus_req_q, bus_req_d;
    logic            vbd_oe_q, vbd_oe_d;
    logic [8:0]      vbd_out_q, vbd_out_d;
    logic            hscrld_b_q, hscrld_b_d;

    logic            w_miss;

    // Line counter; the strobe is registered from the next count so it lines
    // up exactly with the cycle where hcount equals PFHST_POS.
    always_comb begin
        hcount_d  = (hcount_q == c_HC_LAST) ? '0 : (hcount_q + c_HC_ONE);
        pfhst_b_d = (hcount_d != c_PFHST);
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        w_miss  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hcount_q == c_HSCRLD && busy_q) begin
                    state_d = S_REQ;
                    win_d   = '0;
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    state_d = S_DRIVE;
                end else if (win_q == c_WIN_LAST) begin
                    state_d = S_IDLE;
                    w_miss  = 1'b1;
                end else begin
                    win_d = win_q + c_WIN_ONE;
                end
            end
            S_DRIVE:  state_d = S_STROBE;
            S_STROBE: state_d = S_HOLD;
            S_HOLD:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Bus-side outputs are decoded from the next state so they are registered
    // and change on the same edge as the state itself.
    always_comb begin
        bus_req_d  = (state_d != S_IDLE);
        vbd_oe_d   = (state_d == S_DRIVE) || (state_d == S_STROBE) || (state_d == S_HOLD);
        hscrld_b_d = (state_d != S_STROBE);
        vbd_out_d  = vbd_out_q;
        if (state_d == S_DRIVE) begin
            vbd_out_d = pend_q;
        end
    end

    always_comb begin
        pend_d   = pend_q;
        busy_d   = busy_q;
        cur_d    = cur_q;
        if (state_q == S_HOLD) begin
            cur_d  = pend_q;
            busy_d = 1'b0;
        end else if (cpu_wr && !busy_q) begin
            pend_d = cpu_data;
            busy_d = 1'b1;
        end
        // A fresh miss takes priority over a simultaneous clear.
        if (w_miss) begin
            missed_d = 1'b1;
        end else if (miss_clr) begin
            missed_d = 1'b0;
        end else begin
            missed_d = missed_q;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            win_q      <= '0;
            hcount_q   <= '0;
            pfhst_b_q  <= 1'b1;
            pend_q     <= '0;
            busy_q     <= 1'b0;
            cur_q      <= '0;
            missed_q   <= 1'b0;
            bus_req_q  <= 1'b0;
            vbd_oe_q   <= 1'b0;
            vbd_out_q  <= '0;
            hscrld_b_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            hcount_q   <= hcount_d;
            pfhst_b_q  <= pfhst_b_d;
            pend_q     <= pend_d;
            busy_q     <= busy_d;
            cur_q      <= cur_d;
            missed_q   <= missed_d;
            bus_req_q  <= bus_req_d;
            vbd_oe_q   <= vbd_oe_d;
            vbd_out_q  <= vbd_out_d;
            hscrld_b_q <= hscrld_b_d;
        end
    end

    assign cpu_busy   = busy_q;
    assign bus_req    = bus_req_q;
    assign vbd_oe     = vbd_oe_q;
    assign vbd_out    = vbd_out_q;
    assign hscrld_b   = hscrld_b_q;
    assign pfhst_b    = pfhst_b_q;
    assign hcount     = hcount_q;
    assign hblank     = (hcount_q >= c_H_ACTIVE);
    assign scroll_cur = cur_q;
    assign missed     = missed_q;

endmodule
`default_nettype wire

// File: doc/playfield_scroll_ctrl.md
Name: playfield_scroll_ctrl

Overview:
Sequencer for the playfield horizontal-scroll datapath. It runs the horizontal line counter and generates the active-low PFHST_b start strobe on every line. It buffers CPU scroll writes in a shadow register and requests the shared VBD bus during horizontal blank. When the bus is granted, it drives the 9-bit scroll value and pulses HSCRLD_b so the value is latched on its rising edge.

Parameters:
H_TOTAL, 456, pixel clocks per line; hcount wraps at H_TOTAL-1.
H_ACTIVE, 336, active pixels; hblank is high for hcount >= H_ACTIVE.
HSCRLD_POS, 340, hcount at which a pending load starts requesting the bus. Legal range is [H_ACTIVE, H_TOTAL-GNT_WINDOW-4].
PFHST_POS, 448, hcount at which PFHST_b pulses low.
GNT_WINDOW, 4, maximum cycles spent in REQ before the load is abandoned for this line.

Ports:
clk  in  1  system clock; everything is rising-edge.
rst_b  in  1  asynchronous active-low reset.
cpu_wr  in  1  one-cycle scroll-write strobe.
cpu_data  in  9  scroll value; bit 8 is the ls74 bit.
cpu_busy  out  1  a pending value is not yet applied; writes are ignored while high.
bus_req  out  1  request for the VBD bus.
bus_gnt  in  1  grant for the VBD bus from the bus owner.
vbd_oe  out  1  drive enable for vbd_out.
vbd_out  out  9  scroll value driven onto VBD.
hscrld_b  out  1  scroll-load strobe, active low.
pfhst_b  out  1  playfield horizontal start strobe, active low.
hcount  out  9  horizontal position.
hblank  out  1  high during blanking.
scroll_cur  out  9  last value actually loaded into the datapath.
missed  out  1  sticky flag: a load was abandoned because no grant arrived.
miss_clr  in  1  clears missed.

Behaviour:
- Reset (asynchronous, immediate):
  - hcount=0.
  - hscrld_b=1, pfhst_b=1.
  - bus_req=0, vbd_oe=0, vbd_out=0.
  - cpu_busy=0, pending register=0, scroll_cur=0, missed=0.
  - FSM=IDLE.
  - A reset mid-load releases the bus at once and loses the pending value.
- Line counter: hcount increments every clk and goes from H_TOTAL-1 to 0. hblank is combinational from hcount.
- pfhst_b is low for exactly the single cycle where hcount==PFHST_POS, on every line. It is independent of the FSM.
- Shadow capture:
  - cpu_wr sampled high while cpu_busy==0 captures cpu_data into pend; cpu_busy=1 from the next cycle.
  - cpu_wr while cpu_busy==1 is dropped silently; pend is unchanged.
- FSM states IDLE, REQ, DRIVE, STROBE, HOLD. All outputs are registered.
  - IDLE: move to REQ when hcount==HSCRLD_POS and cpu_busy==1.
  - REQ: bus_req=1; a cycle counter starts at 0.
    - If bus_gnt is sampled 1, go to DRIVE.
    - Otherwise, when the counter reaches GNT_WINDOW-1, go to IDLE: bus_req=0, missed=1, pend and cpu_busy retained for the next line.
  - DRIVE: bus_req=1, vbd_oe=1, vbd_out=pend, hscrld_b=1.
  - STROBE: as DRIVE, but hscrld_b=0 for exactly one cycle.
  - HOLD: vbd_oe=1, hscrld_b=1; the rising edge of hscrld_b occurs at entry, with data stable. In HOLD the block sets scroll_cur=pend and clears cpu_busy, then goes to IDLE. At IDLE, bus_req=0 and vbd_oe=0.
- The grant is assumed held from DRIVE through HOLD. If bus_gnt drops mid-transfer, the sequence completes anyway; the bus owner is responsible for that.
- Latency: HSCRLD_POS to the hscrld_b falling edge is 3 cycles with an immediate grant (REQ, DRIVE, STROBE). cpu_busy falls 1 cycle after STROBE.
- At most one load per line. REQ is only entered at hcount==HSCRLD_POS.
- If miss_clr and a new miss occur in the same cycle, the miss wins and missed stays 1.
- vbd_out holds its last value when vbd_oe=0; this has no functional meaning.

Test Plan:
- Reset, then 2 lines idle → hcount wraps 455 to 0; pfhst_b low only at hcount 448; hscrld_b constantly 1; bus_req 0.
- cpu_wr with cpu_data=0x1A5 at hcount 100, bus_gnt tied 1 → bus_req rises at 341; hscrld_b low only during hcount 343; vbd_out=0x1A5 with vbd_oe=1 for hcounts 342-344; scroll_cur=0x1A5 and cpu_busy=0 after 344.
- Pending write, bus_gnt held 0 → bus_req high for exactly 4 cycles, then drops; missed=1; no hscrld_b pulse; grant on the next line loads the value.
- Second cpu_wr=0x055 while 0x1A5 is pending → dropped; 0x1A5 is loaded; scroll_cur=0x1A5.
- miss_clr pulse → missed=0; miss_clr in the same cycle as a new miss → missed=1.
- rst_b asserted during STROBE → vbd_oe=0, bus_req=0, hscrld_b=1 immediately; cpu_busy=0; after release, no load on the following line.
